// File: rtl/gray_bin_seq.sv
// Serial Gray-to-binary decoder: accepts one word, resolves it MSB-first one bit per clock,
// checks it is a single Gray step from the last delivered word, and holds the result until taken.
module gray_bin_seq #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] g,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] b,
    output logic         step_err,
    output logic         dir_up
);

    localparam int IW = (W > 2) ? $clog2(W) : 1;
    localparam logic [W-1:0]  B_ONE   = 1;
    localparam logic [IW-1:0] IDX_ONE = 1;
    localparam logic [IW-1:0] IDX_TOP = IW'(W - 1);

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  g_q, g_d;
    logic [W-1:0]  b_q, b_d;
    logic [W-1:0]  prev_g_q, prev_g_d;
    logic [W-1:0]  prev_b_q, prev_b_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          has_prev_q, has_prev_d;
    logic          step_err_q, step_err_d;
    logic          dir_up_q, dir_up_d;
    logic [W:0]    b_ext;

    // A zero above the MSB makes the top bit resolve to g itself, like every lower bit.
    assign b_ext = {1'b0, b_q};

    always_comb begin
        state_d    = state_q;
        g_d        = g_q;
        b_d        = b_q;
        prev_g_d   = prev_g_q;
        prev_b_d   = prev_b_q;
        idx_d      = idx_q;
        has_prev_d = has_prev_q;
        step_err_d = step_err_q;
        dir_up_d   = dir_up_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    g_d     = g;
                    idx_d   = IDX_TOP;
                    state_d = CONV;
                end
            end
            CONV: begin
                for (int i = 0; i < W; i++) begin
                    if (idx_q == IW'(i)) begin
                        b_d[i] = b_ext[i+1] ^ g_q[i];
                    end
                end
                idx_d = idx_q - IDX_ONE;
                if (idx_q == '0) begin
                    state_d    = DONE;
                    step_err_d = has_prev_q && ($countones(g_q ^ prev_g_q) != 1);
                    dir_up_d   = has_prev_q && (b_d == prev_b_q + B_ONE);
                end
            end
            DONE: begin
                if (out_ready) begin
                    prev_g_d   = g_q;
                    prev_b_d   = b_q;
                    has_prev_d = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            g_q        <= '0;
            b_q        <= '0;
            prev_g_q   <= '0;
            prev_b_q   <= '0;
            idx_q      <= '0;
            has_prev_q <= 1'b0;
            step_err_q <= 1'b0;
            dir_up_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            g_q        <= g_d;
            b_q        <= b_d;
            prev_g_q   <= prev_g_d;
            prev_b_q   <= prev_b_d;
            idx_q      <= idx_d;
            has_prev_q <= has_prev_d;
            step_err_q <= step_err_d;
            dir_up_q   <= dir_up_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign b         = b_q;
    assign step_err  = step_err_q;
    assign dir_up    = dir_up_q;

endmodule
